// File: rtl/reg_bank_pkg.sv
// Shared constants for the 32-entry MIPS-style register bank.
// Used by reg_bank, which optionally forwards writes to reads when REG_BANK_BYPASS_EN is defined.
package reg_bank_pkg;

   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_W-1:0] REG_30   = 5'd30;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

   localparam int unsigned SP_RESET_DEFAULT = 227;

   // Register 0 is hardwired to zero, so it is the only index that never accepts data
   function automatic logic isWritable(input logic [ADDR_W-1:0] addr);
      return addr != REG_ZERO;
   endfunction

endpackage

// File: rtl/reg_bank.sv
// Register bank: 32 x DATA_W, two combinational read ports, one clocked write port.
// Define REG_BANK_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int unsigned SP_RESET = SP_RESET_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Reset clears everything except the stack pointer, which starts at SP_RESET;
   // reset also dominates any write presented on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == int'(REG_SP)) ? DATA_W'(SP_RESET) : '0;
         end
      end else if (reg_write && isWritable(write_reg)) begin
         regs[write_reg] <= write_data;
      end
   end

   // Read port A: register 0 is forced to zero independently of the array contents
   always_comb begin
      read_data1 = (read_reg1 == REG_ZERO) ? '0 : regs[read_reg1];
`ifdef REG_BANK_BYPASS_EN
      if (!reset && reg_write && isWritable(write_reg) && (read_reg1 == write_reg)) begin
         read_data1 = write_data;
      end
`endif
   end

   // Read port B mirrors port A so both ports return identical data for the same index
   always_comb begin
      read_data2 = (read_reg2 == REG_ZERO) ? '0 : regs[read_reg2];
`ifdef REG_BANK_BYPASS_EN
      if (!reset && reg_write && isWritable(write_reg) && (read_reg2 == write_reg)) begin
         read_data2 = write_data;
      end
`endif
   end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios then randomized traffic against an array model.
// Honours REG_BANK_BYPASS_EN when computing expected same-cycle reads.
module tb_reg_bank;

   localparam int          DATA_W   = 32;
   localparam int unsigned SP_RESET = 227;

   logic              clk = 1'b0;
   logic              reset;
   logic              regWrite;
   logic [4:0]        readReg1;
   logic [4:0]        readReg2;
   logic [4:0]        writeReg;
   logic [DATA_W-1:0] writeData;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;

   logic [DATA_W-1:0] model [32];
   int errorCount = 0;
   int checkCount = 0;

   reg_bank #(.DATA_W(DATA_W), .SP_RESET(SP_RESET)) dut (
      .clk        (clk),
      .reset      (reset),
      .reg_write  (regWrite),
      .read_reg1  (readReg1),
      .read_reg2  (readReg2),
      .write_reg  (writeReg),
      .write_data (writeData),
      .read_data1 (readData1),
      .read_data2 (readData2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic modelReset();
      foreach (model[i]) model[i] = '0;
      model[29] = SP_RESET;
   endtask

   // What a read port should show right now, from the architectural rules alone
   function automatic logic [DATA_W-1:0] expectRead(input logic [4:0] addr);
      if (addr == 0) return '0;
`ifdef REG_BANK_BYPASS_EN
      if (!reset && regWrite && writeReg != 0 && addr == writeReg) return writeData;
`endif
      return model[addr];
   endfunction

   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [DATA_W-1:0] wd,
                                input logic [4:0] ra1, input logic [4:0] ra2);
      regWrite  = we;
      writeReg  = wa;
      writeData = wd;
      readReg1  = ra1;
      readReg2  = ra2;
      #1;
   endtask

   task automatic checkReads(input string tag);
      checkOutput({tag, "_rd1"}, readData1, expectRead(readReg1));
      checkOutput({tag, "_rd2"}, readData2, expectRead(readReg2));
   endtask

   // One rising edge; the model commits the write the DUT should have taken, then we return mid-low phase
   task automatic clockEdge();
      @(posedge clk);
      if (!reset && regWrite && writeReg != 0) model[writeReg] = writeData;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      modelReset();
      applyStimulus(1'b0, 5'd0, '0, 5'd29, 5'd5);
      checkOutput("reset_sp", readData1, 32'd227);
      checkOutput("reset_r5", readData2, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd31);
      checkReads("after_reset");

      applyStimulus(1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2);
      clockEdge();
      applyStimulus(1'b0, 5'd0, '0, 5'd8, 5'd8);
      checkOutput("basic_wr_a", readData1, 32'hDEADBEEF);
      checkOutput("basic_wr_b", readData2, 32'hDEADBEEF);

      applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd3, 5'd4);
      clockEdge();
      applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0);
      checkOutput("zero_reg", readData1, 32'd0);

      applyStimulus(1'b0, 5'd9, 32'hFFFFFFFF, 5'd9, 5'd8);
      clockEdge();
      applyStimulus(1'b0, 5'd0, '0, 5'd9, 5'd8);
      checkOutput("wr_disabled", readData1, 32'd0);
      checkOutput("wr_disabled_keep", readData2, 32'hDEADBEEF);

      applyStimulus(1'b1, 5'd31, 32'h11111111, 5'd0, 5'd0);
      clockEdge();
      applyStimulus(1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31);
`ifdef REG_BANK_BYPASS_EN
      checkOutput("ra_pre_edge", readData1, 32'h00400010);
`else
      checkOutput("ra_pre_edge", readData1, 32'h11111111);
`endif
      clockEdge();
      applyStimulus(1'b0, 5'd0, '0, 5'd31, 5'd30);
      checkOutput("ra_post_edge", readData1, 32'h00400010);

      // Asynchronous reset in the middle of the low phase, no clock edge involved
      applyStimulus(1'b1, 5'd5, 32'h0000A5A5, 5'd5, 5'd5);
      clockEdge();
      applyStimulus(1'b0, 5'd0, '0, 5'd29, 5'd5);
      checkOutput("pre_async_r5", readData2, 32'h0000A5A5);
      #1;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("async_rst_sp", readData1, 32'd227);
      checkOutput("async_rst_r5", readData2, 32'd0);

      // Reset held across an edge that carries a write to SP
      applyStimulus(1'b1, 5'd29, 32'd0, 5'd29, 5'd8);
      clockEdge();
      reset = 1'b0;
      applyStimulus(1'b0, 5'd0, '0, 5'd29, 5'd8);
      checkOutput("rst_vs_wr_sp", readData1, 32'd227);
      checkOutput("rst_vs_wr_r8", readData2, 32'd0);

      applyStimulus(1'b1, 5'd29, 32'h7FFFFFF0, 5'd0, 5'd0);
      clockEdge();
      applyStimulus(1'b0, 5'd0, '0, 5'd29, 5'd29);
      checkOutput("first_wr_sp", readData1, 32'h7FFFFFF0);

      for (int n = 0; n < 400; n++) begin
         logic       we;
         logic [4:0] wa, ra1, ra2;
         we  = ($urandom_range(0, 3) != 0);
         wa  = 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         applyStimulus(we, wa, $urandom, ra1, ra2);
         checkReads("rand_pre");
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b1;
            #1;
            modelReset();
            checkReads("rand_rst");
            if ($urandom_range(0, 1) == 0) begin
               reset = 1'b0;
               #1;
            end
         end
         clockEdge();
         reset = 1'b0;
         applyStimulus(1'b0, 5'd0, '0, ra1, wa);
         checkReads("rand_post");
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
